// File: rtl/lock_ctrl.sv
// Combination-lock sequencer fed by one-cycle keypad strobes: buffers digits, checks them
// against a stored password and drives unlock/alarm with timed lockout, auto-relock and password change.
module lock_ctrl #(
  parameter int                  CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_PW   = 16'h1234,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCKOUT_CYCLES = 5000000,
  parameter int                  UNLOCK_CYCLES  = 10000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic                  unlock,
  output logic                  alarm,
  output logic [3:0]            entry_cnt,
  output logic [4*CODE_LEN-1:0] entry_buf,
  output logic [2:0]            fail_cnt,
  output logic [2:0]            state_o,
  output logic                  pw_done
);

  localparam int W       = 4 * CODE_LEN;
  localparam int MAX_CYC = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] OPEN_LAST = TW'(UNLOCK_CYCLES - 1);
  localparam logic [3:0]    FULL      = 4'(CODE_LEN);
  localparam logic [2:0]    FAIL_MAX  = 3'(MAX_FAIL);

  localparam logic [3:0] K_ENTER  = 4'ha;
  localparam logic [3:0] K_CLEAR  = 4'hb;
  localparam logic [3:0] K_CHANGE = 4'hc;
  localparam logic [3:0] K_LOCK   = 4'hd;

  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_NEW_PW  = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    entry_buf_reg, entry_buf_next;
  logic [3:0]      entry_cnt_reg, entry_cnt_next;
  logic [W-1:0]    pw_reg, pw_next;
  logic [2:0]      fail_reg, fail_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            unlock_reg, unlock_next;
  logic            alarm_reg, alarm_next;
  logic            pw_done_reg, pw_done_next;

  logic [W-1:0]    shifted_buf;
  logic            is_digit, entry_full, match;
  logic [2:0]      fail_inc;

  // New digit enters at the low nibble; older digits move up one nibble
  assign shifted_buf[3:0] = key_code;
  for (genvar gi = 1; gi < CODE_LEN; gi++) begin : g_shift
    assign shifted_buf[4*gi +: 4] = entry_buf_reg[4*(gi-1) +: 4];
  end

  assign is_digit   = (key_code <= 4'd9);
  assign entry_full = (entry_cnt_reg == FULL);
  assign match      = entry_full && (entry_buf_reg == pw_reg);
  assign fail_inc   = (fail_reg >= FAIL_MAX) ? FAIL_MAX : fail_reg + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_LOCKED;
      entry_buf_reg <= '0;
      entry_cnt_reg <= '0;
      pw_reg        <= DEFAULT_PW;
      fail_reg      <= '0;
      timer_reg     <= '0;
      unlock_reg    <= 1'b0;
      alarm_reg     <= 1'b0;
      pw_done_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      entry_buf_reg <= entry_buf_next;
      entry_cnt_reg <= entry_cnt_next;
      pw_reg        <= pw_next;
      fail_reg      <= fail_next;
      timer_reg     <= timer_next;
      unlock_reg    <= unlock_next;
      alarm_reg     <= alarm_next;
      pw_done_reg   <= pw_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    entry_buf_next = entry_buf_reg;
    entry_cnt_next = entry_cnt_reg;
    pw_next        = pw_reg;
    fail_next      = fail_reg;
    timer_next     = timer_reg;
    unlock_next    = unlock_reg;
    alarm_next     = alarm_reg;
    pw_done_next   = 1'b0;

    // Digit entry and CLEAR work the same whether unlocking or choosing a new password
    if (key_valid && (state_reg == S_LOCKED || state_reg == S_NEW_PW)) begin
      if (is_digit) begin
        if (!entry_full) begin
          entry_buf_next = shifted_buf;
          entry_cnt_next = entry_cnt_reg + 4'd1;
        end
      end else if (key_code == K_CLEAR) begin
        entry_buf_next = '0;
        entry_cnt_next = '0;
      end
    end

    case (state_reg)
      S_LOCKED: begin
        if (key_valid && key_code == K_ENTER) state_next = S_CHECK;
      end
      S_CHECK: begin
        entry_buf_next = '0;
        entry_cnt_next = '0;
        timer_next     = '0;
        if (match) begin
          state_next  = S_OPEN;
          unlock_next = 1'b1;
          fail_next   = '0;
        end else begin
          fail_next = fail_inc;
          if (fail_inc == FAIL_MAX) begin
            state_next = S_LOCKOUT;
            alarm_next = 1'b1;
          end else begin
            state_next = S_LOCKED;
          end
        end
      end
      S_OPEN: begin
        if (key_valid) begin
          timer_next = '0;
          if (key_code == K_LOCK) begin
            state_next  = S_LOCKED;
            unlock_next = 1'b0;
          end else if (key_code == K_CHANGE) begin
            state_next     = S_NEW_PW;
            entry_buf_next = '0;
            entry_cnt_next = '0;
          end
        end else if (timer_reg == OPEN_LAST) begin
          state_next  = S_LOCKED;
          unlock_next = 1'b0;
          timer_next  = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      S_NEW_PW: begin
        if (key_valid) begin
          timer_next = '0;
          if (key_code == K_ENTER && entry_full) begin
            pw_next        = entry_buf_reg;
            pw_done_next   = 1'b1;
            entry_buf_next = '0;
            entry_cnt_next = '0;
            state_next     = S_OPEN;
          end else if (key_code == K_LOCK) begin
            state_next     = S_LOCKED;
            unlock_next    = 1'b0;
            entry_buf_next = '0;
            entry_cnt_next = '0;
          end
        end else if (timer_reg == OPEN_LAST) begin
          // Idle timeout abandons the half-entered password
          state_next     = S_LOCKED;
          unlock_next    = 1'b0;
          entry_buf_next = '0;
          entry_cnt_next = '0;
          timer_next     = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      S_LOCKOUT: begin
        if (timer_reg == LOCK_LAST) begin
          state_next = S_LOCKED;
          alarm_next = 1'b0;
          fail_next  = '0;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        state_next  = S_LOCKED;
        unlock_next = 1'b0;
        alarm_next  = 1'b0;
        timer_next  = '0;
      end
    endcase
  end

  assign unlock    = unlock_reg;
  assign alarm     = alarm_reg;
  assign entry_cnt = entry_cnt_reg;
  assign entry_buf = entry_buf_reg;
  assign fail_cnt  = fail_reg;
  assign state_o   = state_reg;
  assign pw_done   = pw_done_reg;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: each scenario builds a step table (key or idle cycle plus the expected
// registered outputs), pushes the expectation as the step is driven and pops it one cycle later.
module tb_lock_ctrl;

  localparam logic [3:0] K_ENTER  = 4'ha;
  localparam logic [3:0] K_CLEAR  = 4'hb;
  localparam logic [3:0] K_CHANGE = 4'hc;
  localparam logic [3:0] K_LOCK   = 4'hd;
  localparam int SL = 0, SC = 1, SO = 2, SN = 3, SX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        unlock, alarm, pw_done;
  logic [3:0]  entry_cnt;
  logic [15:0] entry_buf;
  logic [2:0]  fail_cnt, state_o;

  lock_ctrl #(
    .CODE_LEN(4), .DEFAULT_PW(16'h1234), .MAX_FAIL(3),
    .LOCKOUT_CYCLES(20), .UNLOCK_CYCLES(30)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .unlock(unlock), .alarm(alarm), .entry_cnt(entry_cnt), .entry_buf(entry_buf),
    .fail_cnt(fail_cnt), .state_o(state_o), .pw_done(pw_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        unl;
    logic        alm;
    logic [2:0]  fail;
    logic [3:0]  cnt;
    logic [15:0] ebuf;
    logic        done;
  } snap_t;

  typedef struct packed { logic rst; logic v; logic [3:0] k; snap_t x; } step_t;
  typedef struct packed { int idx; snap_t v; } exp_t;

  step_t steps[$];
  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic snap_t mk(int st, bit u, bit a, int f, int c, logic [15:0] b, bit d);
    snap_t s;
    s.st = 3'(st); s.unl = u; s.alm = a; s.fail = 3'(f);
    s.cnt = 4'(c); s.ebuf = b; s.done = d;
    return s;
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.st = state_o; s.unl = unlock; s.alm = alarm; s.fail = fail_cnt;
    s.cnt = entry_cnt; s.ebuf = entry_buf; s.done = pw_done;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d unl=%b alm=%b fail=%0d cnt=%0d buf=%h pwd=%b",
                     s.st, s.unl, s.alm, s.fail, s.cnt, s.ebuf, s.done);
  endfunction

  function automatic void kp(logic [3:0] k, snap_t x);
    steps.push_back('{1'b0, 1'b1, k, x});
  endfunction

  function automatic void idl(snap_t x);
    steps.push_back('{1'b0, 1'b0, 4'h0, x});
  endfunction

  // Keys the n low digits of code, most significant first, expecting the buffer to fill up
  function automatic void digits(logic [15:0] code, int n, int st, bit u, int f);
    logic [15:0] part;
    for (int i = 0; i < n; i++) begin
      part = code >> (4 * (n - 1 - i));
      kp(part[3:0], mk(st, u, 0, f, i + 1, part, 0));
    end
  endfunction

  function automatic void open_seq(logic [15:0] code, int f);
    digits(code, 4, SL, 0, f);
    kp(K_ENTER, mk(SC, 0, 0, f, 4, code, 0));
    idl(mk(SO, 1, 0, 0, 0, 16'h0, 0));
  endfunction

  function automatic void fail_seq(logic [15:0] code, int n, int f);
    digits(code, n, SL, 0, f);
    kp(K_ENTER, mk(SC, 0, 0, f, n, code, 0));
    if (f + 1 == 3) idl(mk(SX, 0, 1, 3, 0, 16'h0, 0));
    else            idl(mk(SL, 0, 0, f + 1, 0, 16'h0, 0));
  endfunction

  task automatic test_reset();
    snap_t got; exp_t e;
    steps.delete();
    steps.push_back('{1'b1, 1'b1, 4'h1, mk(SL, 0, 0, 0, 0, 16'h0, 0)});
    steps.push_back('{1'b1, 1'b1, 4'h2, mk(SL, 0, 0, 0, 0, 16'h0, 0)});
    kp(4'h7, mk(SL, 0, 0, 0, 1, 16'h0007, 0));
    kp(K_CLEAR, mk(SL, 0, 0, 0, 0, 16'h0, 0));
    foreach (steps[i]) begin
      exp_q.push_back('{i, steps[i].x});
      reset = steps[i].rst; key_valid = steps[i].v; key_code = steps[i].k;
      @(negedge clk);
      reset = 1'b0; key_valid = 1'b0;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %s, want %s", e.idx, fmt(got), fmt(e.v));
      end else $display("reset[%0d]: %s", e.idx, fmt(got));
    end
  endtask

  task automatic test_unlock();
    snap_t got; exp_t e;
    steps.delete();
    open_seq(16'h1234, 0);
    kp(K_LOCK, mk(SL, 0, 0, 0, 0, 16'h0, 0));
    foreach (steps[i]) begin
      exp_q.push_back('{i, steps[i].x});
      reset = steps[i].rst; key_valid = steps[i].v; key_code = steps[i].k;
      @(negedge clk);
      reset = 1'b0; key_valid = 1'b0;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL unlock[%0d]: got %s, want %s", e.idx, fmt(got), fmt(e.v));
      end else $display("unlock[%0d]: %s", e.idx, fmt(got));
    end
  endtask

  task automatic test_back_to_back();
    snap_t got; exp_t e;
    steps.delete();
    digits(16'h0012, 2, SL, 0, 0);
    kp(K_CLEAR, mk(SL, 0, 0, 0, 0, 16'h0, 0));
    kp(4'h3, mk(SL, 0, 0, 0, 1, 16'h0003, 0));
    kp(K_CHANGE, mk(SL, 0, 0, 0, 1, 16'h0003, 0));
    kp(K_LOCK, mk(SL, 0, 0, 0, 1, 16'h0003, 0));
    kp(4'he, mk(SL, 0, 0, 0, 1, 16'h0003, 0));
    kp(4'hf, mk(SL, 0, 0, 0, 1, 16'h0003, 0));
    kp(K_CLEAR, mk(SL, 0, 0, 0, 0, 16'h0, 0));
    digits(16'h1234, 4, SL, 0, 0);
    kp(K_ENTER, mk(SC, 0, 0, 0, 4, 16'h1234, 0));
    kp(4'h7, mk(SO, 1, 0, 0, 0, 16'h0, 0));
    kp(4'h8, mk(SO, 1, 0, 0, 0, 16'h0, 0));
    kp(K_ENTER, mk(SO, 1, 0, 0, 0, 16'h0, 0));
    kp(K_CLEAR, mk(SO, 1, 0, 0, 0, 16'h0, 0));
    kp(K_LOCK, mk(SL, 0, 0, 0, 0, 16'h0, 0));
    foreach (steps[i]) begin
      exp_q.push_back('{i, steps[i].x});
      reset = steps[i].rst; key_valid = steps[i].v; key_code = steps[i].k;
      @(negedge clk);
      reset = 1'b0; key_valid = 1'b0;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %s, want %s", e.idx, fmt(got), fmt(e.v));
      end else $display("back_to_back[%0d]: %s", e.idx, fmt(got));
    end
  endtask

  task automatic test_entry_len();
    snap_t got; exp_t e;
    steps.delete();
    digits(16'h1234, 4, SL, 0, 0);
    kp(4'h5, mk(SL, 0, 0, 0, 4, 16'h1234, 0));
    kp(K_ENTER, mk(SC, 0, 0, 0, 4, 16'h1234, 0));
    idl(mk(SO, 1, 0, 0, 0, 16'h0, 0));
    kp(K_LOCK, mk(SL, 0, 0, 0, 0, 16'h0, 0));
    fail_seq(16'h0012, 2, 0);
    open_seq(16'h1234, 1);
    kp(K_LOCK, mk(SL, 0, 0, 0, 0, 16'h0, 0));
    foreach (steps[i]) begin
      exp_q.push_back('{i, steps[i].x});
      reset = steps[i].rst; key_valid = steps[i].v; key_code = steps[i].k;
      @(negedge clk);
      reset = 1'b0; key_valid = 1'b0;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL entry_len[%0d]: got %s, want %s", e.idx, fmt(got), fmt(e.v));
      end else $display("entry_len[%0d]: %s", e.idx, fmt(got));
    end
  endtask

  task automatic test_lockout();
    snap_t got; exp_t e;
    logic [3:0] lk [5] = '{4'h1, 4'h2, 4'h3, 4'h4, K_ENTER};
    steps.delete();
    for (int a = 0; a < 3; a++) fail_seq(16'h1235, 4, a);
    // Lockout entered on the previous step (cycle 0); keys are ignored, release at cycle 20
    foreach (lk[j]) kp(lk[j], mk(SX, 0, 1, 3, 0, 16'h0, 0));
    repeat (14) idl(mk(SX, 0, 1, 3, 0, 16'h0, 0));
    idl(mk(SL, 0, 0, 0, 0, 16'h0, 0));
    open_seq(16'h1234, 0);
    kp(K_LOCK, mk(SL, 0, 0, 0, 0, 16'h0, 0));
    foreach (steps[i]) begin
      exp_q.push_back('{i, steps[i].x});
      reset = steps[i].rst; key_valid = steps[i].v; key_code = steps[i].k;
      @(negedge clk);
      reset = 1'b0; key_valid = 1'b0;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL lockout[%0d]: got %s, want %s", e.idx, fmt(got), fmt(e.v));
      end else $display("lockout[%0d]: %s", e.idx, fmt(got));
    end
  endtask

  task automatic test_relock();
    snap_t got; exp_t e;
    steps.delete();
    open_seq(16'h1234, 0);
    repeat (29) idl(mk(SO, 1, 0, 0, 0, 16'h0, 0));
    idl(mk(SL, 0, 0, 0, 0, 16'h0, 0));
    open_seq(16'h1234, 0);
    repeat (24) idl(mk(SO, 1, 0, 0, 0, 16'h0, 0));
    kp(4'h5, mk(SO, 1, 0, 0, 0, 16'h0, 0));
    repeat (29) idl(mk(SO, 1, 0, 0, 0, 16'h0, 0));
    idl(mk(SL, 0, 0, 0, 0, 16'h0, 0));
    foreach (steps[i]) begin
      exp_q.push_back('{i, steps[i].x});
      reset = steps[i].rst; key_valid = steps[i].v; key_code = steps[i].k;
      @(negedge clk);
      reset = 1'b0; key_valid = 1'b0;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL relock[%0d]: got %s, want %s", e.idx, fmt(got), fmt(e.v));
      end else $display("relock[%0d]: %s", e.idx, fmt(got));
    end
  endtask

  task automatic test_pw_change();
    snap_t got; exp_t e;
    steps.delete();
    open_seq(16'h1234, 0);
    kp(K_CHANGE, mk(SN, 1, 0, 0, 0, 16'h0, 0));
    kp(4'h9, mk(SN, 1, 0, 0, 1, 16'h0009, 0));
    kp(K_ENTER, mk(SN, 1, 0, 0, 1, 16'h0009, 0));
    kp(K_CLEAR, mk(SN, 1, 0, 0, 0, 16'h0, 0));
    digits(16'h9876, 4, SN, 1, 0);
    kp(K_ENTER, mk(SO, 1, 0, 0, 0, 16'h0, 1));
    idl(mk(SO, 1, 0, 0, 0, 16'h0, 0));
    kp(K_LOCK, mk(SL, 0, 0, 0, 0, 16'h0, 0));
    fail_seq(16'h1234, 4, 0);
    open_seq(16'h9876, 1);
    kp(K_LOCK, mk(SL, 0, 0, 0, 0, 16'h0, 0));
    foreach (steps[i]) begin
      exp_q.push_back('{i, steps[i].x});
      reset = steps[i].rst; key_valid = steps[i].v; key_code = steps[i].k;
      @(negedge clk);
      reset = 1'b0; key_valid = 1'b0;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL pw_change[%0d]: got %s, want %s", e.idx, fmt(got), fmt(e.v));
      end else $display("pw_change[%0d]: %s", e.idx, fmt(got));
    end
  endtask

  task automatic test_reset_newpw();
    snap_t got; exp_t e;
    steps.delete();
    open_seq(16'h9876, 0);
    kp(K_CHANGE, mk(SN, 1, 0, 0, 0, 16'h0, 0));
    digits(16'h0055, 2, SN, 1, 0);
    steps.push_back('{1'b1, 1'b0, 4'h0, mk(SL, 0, 0, 0, 0, 16'h0, 0)});
    fail_seq(16'h9876, 4, 0);
    open_seq(16'h1234, 1);
    kp(K_LOCK, mk(SL, 0, 0, 0, 0, 16'h0, 0));
    foreach (steps[i]) begin
      exp_q.push_back('{i, steps[i].x});
      reset = steps[i].rst; key_valid = steps[i].v; key_code = steps[i].k;
      @(negedge clk);
      reset = 1'b0; key_valid = 1'b0;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL reset_newpw[%0d]: got %s, want %s", e.idx, fmt(got), fmt(e.v));
      end else $display("reset_newpw[%0d]: %s", e.idx, fmt(got));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    @(negedge clk);
    test_reset();
    test_unlock();
    test_back_to_back();
    test_entry_len();
    test_lockout();
    test_relock();
    test_pw_change();
    test_reset_newpw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
